wb_ram_bank: RTL and testbench

Single 32K x 32-bit RAM bank with independent write and read ports and per-byte write enables, targeting Xilinx block RAM inference. It sits under the Wishbone RAM wrapper, which instantiates one or more banks and gates each with `bank_select`. The Wishbone protocol is handled in the wrapper; this block is pure storage plus a registered read path.

---
 rtl/wb_ram_bank_pkg.sv | 13 +
 rtl/wb_ram_bank_if.sv | 23 ++
 rtl/wb_ram_bank_byte_lane.sv | 33 +++
 rtl/wb_ram_bank.sv | 41 ++++
 tb/tb_wb_ram_bank.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/wb_ram_bank_pkg.sv
// Shared constants and types for the Wishbone RAM bank and its byte lanes.
package wb_ram_pkg;

   localparam int ADDR_WIDTH = 15;
   localparam int DATA_WIDTH = 32;
   localparam int BYTE_LANES = DATA_WIDTH / 8;
   localparam int DEPTH      = 1 << ADDR_WIDTH;

   typedef logic [DATA_WIDTH-1:0] ram_word_t;
   typedef logic [ADDR_WIDTH-1:0] ram_addr_t;
   typedef logic [BYTE_LANES-1:0] ram_be_t;

endpackage

// File: rtl/wb_ram_bank_if.sv
// Storage-side port bundle of one RAM bank: no handshake, every selected
// edge is an access (write when any we bit is set, read always).
interface wb_ram_bank_if;
   import wb_ram_pkg::*;

   logic      bank_select;
   ram_be_t   we;
   ram_word_t din;
   ram_addr_t waddr;
   ram_addr_t raddr;
   ram_word_t dout;

   modport master (
      output bank_select, we, din, waddr, raddr,
      input  dout
   );

   modport slave (
      input  bank_select, we, din, waddr, raddr,
      output dout
   );

endinterface

// File: rtl/wb_ram_bank_byte_lane.sv
// One 8-bit lane of the bank: simple dual-port array, read-first, written in
// the shape block-RAM inference expects (no reset on array or read register).
module wb_ram_byte_lane
   import wb_ram_pkg::*;
(
   input  logic      i_clk,
   input  logic      i_we,
   input  logic      i_re,
   input  ram_addr_t i_waddr,
   input  ram_addr_t i_raddr,
   input  logic [7:0] i_din,
   output logic [7:0] o_dout
);

   logic [7:0] r_mem [0:DEPTH-1];
   logic [7:0] r_dout;

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_din;
      end
   end

   // Separate process reads the old array value on a same-address write.
   always_ff @(posedge i_clk) begin
      if (i_re) begin
         r_dout <= r_mem[i_raddr];
      end
   end

   assign o_dout = r_dout;

endmodule

// File: rtl/wb_ram_bank.sv
// 32K x 32 RAM bank: four byte lanes with bank_select gating and a read
// output that is zero when deselected or in reset, for OR-combining banks.
module wb_ram_bank
   import wb_ram_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   wb_ram_bank_if.slave bus
);

   logic      w_access;
   ram_word_t w_rd_data;
   logic      r_rd_valid;

   assign w_access = rst & bus.bank_select;

   for (genvar g = 0; g < BYTE_LANES; g++) begin : g_lane
      wb_ram_byte_lane u_lane (
         .i_clk   (clk),
         .i_we    (w_access & bus.we[g]),
         .i_re    (w_access),
         .i_waddr (bus.waddr),
         .i_raddr (bus.raddr),
         .i_din   (bus.din[8*g +: 8]),
         .o_dout  (w_rd_data[8*g +: 8])
      );
   end

   // The BRAM read register cannot reset, so this async-reset qualifier is
   // the output register: it zeroes dout at once and discards pending reads.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rd_valid <= 1'b0;
      end else begin
         r_rd_valid <= bus.bank_select;
      end
   end

   assign bus.dout = r_rd_valid ? w_rd_data : '0;

endmodule

// File: tb/tb_wb_ram_bank.sv
// Directed bench for wb_ram_bank: reset, full/partial writes, collision,
// deselect gating, address extremes and retention across reset.
module tb_wb_ram_bank;
   import wb_ram_pkg::*;

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;

   wb_ram_bank_if bus_if ();

   wb_ram_bank u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input ram_word_t obs, input ram_word_t exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wr(input ram_addr_t a, input ram_word_t d, input ram_be_t be);
      bus_if.waddr = a;
      bus_if.din   = d;
      bus_if.we    = be;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst                = 1'b0;
      bus_if.bank_select = 1'b1;
      bus_if.we          = 4'h0;
      bus_if.din         = 32'h0;
      bus_if.waddr       = 15'h0;
      bus_if.raddr       = 15'h0;

      step();
      step();
      check("reset_hold", bus_if.dout, 32'h0);
      rst = 1'b1;

      wr(15'h0010, 32'hDEADBEEF, 4'hF);
      step();
      bus_if.we    = 4'h0;
      bus_if.raddr = 15'h0010;
      step();
      check("full_word", bus_if.dout, 32'hDEADBEEF);
      step();
      check("read_hold", bus_if.dout, 32'hDEADBEEF);

      #2 rst = 1'b0;
      #1 check("async_reset", bus_if.dout, 32'h0);
      wr(15'h0010, 32'h0, 4'hF);
      step();
      check("reset_hold_edge", bus_if.dout, 32'h0);
      rst = 1'b1;
      bus_if.we = 4'h0;
      step();
      check("write_blocked_in_reset", bus_if.dout, 32'hDEADBEEF);

      wr(15'h0030, 32'h11223344, 4'hF);
      step();
      wr(15'h0030, 32'hAABBCCDD, 4'b0101);
      step();
      bus_if.we    = 4'h0;
      bus_if.raddr = 15'h0030;
      step();
      check("byte_en_0101", bus_if.dout, 32'h11BB33DD);
      wr(15'h0030, 32'h55667788, 4'b1010);
      step();
      bus_if.we = 4'h0;
      step();
      check("byte_en_1010", bus_if.dout, 32'h55BB77DD);
      wr(15'h0030, 32'h99999999, 4'h0);
      step();
      step();
      check("byte_en_none", bus_if.dout, 32'h55BB77DD);

      wr(15'h0100, 32'h00000001, 4'hF);
      step();
      wr(15'h0100, 32'h00000002, 4'hF);
      bus_if.raddr = 15'h0100;
      step();
      check("collision_old", bus_if.dout, 32'h00000001);
      bus_if.we = 4'h0;
      step();
      check("collision_new", bus_if.dout, 32'h00000002);

      wr(15'h0200, 32'hCAFEF00D, 4'hF);
      bus_if.raddr = 15'h0030;
      step();
      check("indep_read", bus_if.dout, 32'h55BB77DD);
      bus_if.we    = 4'h0;
      bus_if.raddr = 15'h0200;
      step();
      check("indep_write", bus_if.dout, 32'hCAFEF00D);

      wr(15'h0020, 32'h12345678, 4'hF);
      step();
      bus_if.bank_select = 1'b0;
      wr(15'h0020, 32'hFFFFFFFF, 4'hF);
      bus_if.raddr = 15'h0020;
      step();
      check("deselect_zero", bus_if.dout, 32'h0);
      step();
      check("deselect_zero_hold", bus_if.dout, 32'h0);
      bus_if.bank_select = 1'b1;
      bus_if.we          = 4'h0;
      step();
      check("reselect_read", bus_if.dout, 32'h12345678);

      wr(15'h0000, 32'hA5A5A5A5, 4'hF);
      step();
      wr(15'h7FFF, 32'h5A5A5A5A, 4'hF);
      step();
      bus_if.we = 4'h0;
      rst = 1'b0;
      #2 check("reset_pulse", bus_if.dout, 32'h0);
      rst = 1'b1;
      bus_if.raddr = 15'h0000;
      step();
      check("addr_min", bus_if.dout, 32'hA5A5A5A5);
      bus_if.raddr = 15'h7FFF;
      step();
      check("addr_max", bus_if.dout, 32'h5A5A5A5A);
      bus_if.raddr = 15'h0010;
      step();
      check("retained_0010", bus_if.dout, 32'hDEADBEEF);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
